// File: rtl/uart_console_writer.sv
// UART-to-VRAM text console: buffers received bytes, interprets CR/LF/BS/FF,
// tracks a cursor and emits single-cycle character writes with scrolling.
module uart_console_writer #(
    parameter int COLS           = 50,
    parameter int ROWS           = 15,
    parameter int FIFO_DEPTH     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        vram_ce,
    output logic [11:0] vram_addr,
    output logic [7:0]  vram_data,
    output logic [5:0]  cursor_col,
    output logic [3:0]  cursor_row,
    output logic [3:0]  top_row,
    output logic        busy,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [11:0] L_COLS_M1  = 12'(COLS - 1);
    localparam logic [11:0] L_COLS     = 12'(COLS);
    localparam logic [11:0] L_CELLS_M1 = 12'(COLS * ROWS - 1);
    localparam logic [3:0]  L_ROW_LAST = 4'(ROWS - 1);
    localparam logic [6:0]  L_COL_END  = 7'(COLS);

    localparam logic [2:0] ST_BOOT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_CLR_ROW = 3'd3;
    localparam logic [2:0] ST_CLR_SCR = 3'd4;

    localparam logic [7:0] C_BS    = 8'h08;
    localparam logic [7:0] C_LF    = 8'h0A;
    localparam logic [7:0] C_FF    = 8'h0C;
    localparam logic [7:0] C_CR    = 8'h0D;
    localparam logic [7:0] C_SPACE = 8'h20;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;

    logic [2:0]  r_state;
    logic [7:0]  r_cmd;
    logic [5:0]  r_col;
    logic [3:0]  r_row;
    logic [3:0]  r_top;
    logic [11:0] r_row_base;
    logic        r_wrapped;
    logic [11:0] r_ccnt;
    logic        r_ce;
    logic [11:0] r_addr;
    logic [7:0]  r_data;

    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [7:0] w_head;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;
    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign w_push  = rx_ready && (!w_full || w_pop);
    assign w_drop  = rx_ready && w_full && !w_pop;
    assign w_head  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= f_inc(r_wp);
            end
            if (w_pop) begin
                r_rp <= f_inc(r_rp);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    logic [11:0] w_cur_addr;
    logic        w_h_print;
    logic        w_h_bs;

    assign w_cur_addr = r_row_base + {6'd0, r_col};
    assign w_h_print  = (w_head >= 8'h20) && (w_head <= 8'h7E);
    assign w_h_bs     = (w_head == C_BS) && (r_col != 6'd0);

    logic       w_c_print;
    logic       w_c_cr;
    logic       w_c_lf;
    logic       w_c_bs;
    logic       w_c_ff;
    logic [6:0] w_col_inc;
    logic       w_eol;
    logic       w_adv;

    assign w_c_print = (r_cmd >= 8'h20) && (r_cmd <= 8'h7E);
    assign w_c_cr    = (r_cmd == C_CR);
    assign w_c_lf    = (r_cmd == C_LF);
    assign w_c_bs    = (r_cmd == C_BS);
    assign w_c_ff    = (r_cmd == C_FF);
    assign w_col_inc = {1'b0, r_col} + 7'd1;
    assign w_eol     = (w_col_inc == L_COL_END);
    assign w_adv     = (w_c_print && w_eol) || w_c_lf;

    logic        w_last_row;
    logic [3:0]  w_row_nx;
    logic [11:0] w_rb_nx;
    logic        w_wrap_nx;
    logic [3:0]  w_top_nx;

    assign w_last_row = (r_row == L_ROW_LAST);
    assign w_row_nx   = w_last_row ? 4'd0 : r_row + 4'd1;
    assign w_rb_nx    = w_last_row ? 12'd0 : r_row_base + L_COLS;
    assign w_wrap_nx  = r_wrapped | w_last_row;
    // Once wrapped, the oldest visible row is the one after the new cursor row.
    assign w_top_nx   = (w_row_nx == L_ROW_LAST) ? 4'd0 : w_row_nx + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_BOOT;
            r_cmd      <= 8'd0;
            r_col      <= 6'd0;
            r_row      <= 4'd0;
            r_top      <= 4'd0;
            r_row_base <= 12'd0;
            r_wrapped  <= 1'b0;
            r_ccnt     <= 12'd0;
            r_ce       <= 1'b0;
            r_addr     <= 12'd0;
            r_data     <= 8'd0;
        end else begin
            r_ce <= 1'b0;
            unique case (r_state)
                ST_BOOT: begin
                    if (CLEAR_ON_RESET != 0) begin
                        r_state <= ST_CLR_SCR;
                        r_ccnt  <= 12'd0;
                        r_ce    <= 1'b1;
                        r_addr  <= 12'd0;
                        r_data  <= C_SPACE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cmd   <= w_head;
                        r_state <= ST_EXEC;
                        // Write is registered here so it is visible during EXEC.
                        if (w_h_print) begin
                            r_ce   <= 1'b1;
                            r_addr <= w_cur_addr;
                            r_data <= w_head;
                        end else if (w_h_bs) begin
                            r_ce   <= 1'b1;
                            r_addr <= w_cur_addr - 12'd1;
                            r_data <= C_SPACE;
                        end
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_IDLE;
                    unique case (1'b1)
                        w_c_print: r_col <= w_eol ? 6'd0 : w_col_inc[5:0];
                        w_c_cr:    r_col <= 6'd0;
                        w_c_lf:    r_col <= 6'd0;
                        w_c_bs: begin
                            if (r_col != 6'd0) begin
                                r_col <= r_col - 6'd1;
                            end
                        end
                        w_c_ff: begin
                            r_state <= ST_CLR_SCR;
                            r_ccnt  <= 12'd0;
                            r_ce    <= 1'b1;
                            r_addr  <= 12'd0;
                            r_data  <= C_SPACE;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                    if (w_adv) begin
                        r_row      <= w_row_nx;
                        r_row_base <= w_rb_nx;
                        r_wrapped  <= w_wrap_nx;
                        if (w_wrap_nx) begin
                            r_top <= w_top_nx;
                        end
                        r_state <= ST_CLR_ROW;
                        r_ccnt  <= 12'd0;
                        r_ce    <= 1'b1;
                        r_addr  <= w_rb_nx;
                        r_data  <= C_SPACE;
                    end
                end
                ST_CLR_ROW: begin
                    if (r_ccnt == L_COLS_M1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ccnt <= r_ccnt + 12'd1;
                        r_ce   <= 1'b1;
                        r_addr <= r_addr + 12'd1;
                    end
                end
                ST_CLR_SCR: begin
                    if (r_ccnt == L_CELLS_M1) begin
                        r_state    <= ST_IDLE;
                        r_col      <= 6'd0;
                        r_row      <= 4'd0;
                        r_top      <= 4'd0;
                        r_row_base <= 12'd0;
                        r_wrapped  <= 1'b0;
                    end else begin
                        r_ccnt <= r_ccnt + 12'd1;
                        r_ce   <= 1'b1;
                        r_addr <= r_addr + 12'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign vram_ce    = r_ce;
    assign vram_addr  = r_addr;
    assign vram_data  = r_data;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign top_row    = r_top;
    assign busy       = (r_state == ST_CLR_ROW) || (r_state == ST_CLR_SCR);
    assign overflow   = r_ovf;

endmodule

// File: doc/uart_console_writer.md
Name: uart_console_writer

Overview:
- Text-console stage between the UART receiver and the LcdVga character VRAM write port.
- Buffers received bytes and interprets control codes (CR, LF, BS, FF).
- Maintains a cursor and emits single-cycle VRAM writes on a COLS x ROWS character grid.
- Replaces the free-running wrap-at-750 address counter in the top level with terminal semantics.

Parameters:
- COLS, 50, characters per row (1..64).
- ROWS, 15, rows per screen (1..16); COLS*ROWS <= 4096.
- FIFO_DEPTH, 4, input byte buffer depth (power of two).
- CLEAR_ON_RESET, 1, when 1 a full-screen clear runs automatically after reset release.

Ports:
- clk, input, 1, system clock (same domain as uart_rx and the VRAM write port).
- reset, input, 1, asynchronous active-low reset.
- rx_data, input, 8, received byte, valid when rx_ready is high.
- rx_ready, input, 1, single-cycle strobe: rx_data is valid.
- vram_ce, output, 1, VRAM write strobe, one cycle per write.
- vram_addr, output, 12, VRAM cell address = row*COLS + col.
- vram_data, output, 8, character code to write.
- cursor_col, output, 6, current cursor column.
- cursor_row, output, 4, current cursor row.
- top_row, output, 4, oldest visible row; display offset for scrolling.
- busy, output, 1, high while a row clear or screen clear is in progress.
- overflow, output, 1, sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset is async, active low. While asserted, all outputs are 0: vram_ce=0, vram_addr=0, vram_data=0, cursor 0,0, top_row=0, busy=0, overflow=0. FIFO is emptied, the wrapped flag is cleared, and any operation in progress is aborted with no further writes.
- After reset release: if CLEAR_ON_RESET=1, enter CLEAR_SCREEN on the first clock; otherwise enter IDLE.
- FIFO:
  - Push when rx_ready=1.
  - Pop when the FSM is in IDLE and the FIFO is not empty.
  - Push and pop in the same cycle while full: push is accepted, no overflow.
  - Push while full with no pop: byte is dropped and overflow is set until reset.
- Address generation: keep a row_base register (row*COLS), updated by +COLS or reset to 0. No multiplier. vram_addr = row_base + col. Maximum address is COLS*ROWS-1.
- FSM states: IDLE, EXEC, CLEAR_ROW, CLEAR_SCREEN.
  - IDLE: pop one byte into a command register, go to EXEC.
  - EXEC decodes the byte in one cycle:
    - 0x20-0x7E: vram_ce=1 at the cursor, vram_data=byte, col+1. If col becomes COLS, do a row advance.
    - 0x0D (CR): col=0, no write.
    - 0x0A (LF): col=0, row advance.
    - 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. If col=0, no operation.
    - 0x0C (FF): enter CLEAR_SCREEN.
    - Any other byte: discarded, no write.
    - EXEC returns to IDLE unless a clear is entered.
  - Row advance:
    - If row<ROWS-1: row+1.
    - Otherwise row=0 and the wrapped flag is set.
    - If wrapped is set after the advance: top_row = (row+1) mod ROWS.
    - Then enter CLEAR_ROW.
  - CLEAR_ROW: COLS consecutive cycles, vram_ce=1, vram_data=0x20, addresses row_base..row_base+COLS-1. busy=1. Then return to IDLE. Cursor stays at col 0 of the new row.
  - CLEAR_SCREEN: COLS*ROWS consecutive cycles writing 0x20 to addresses 0..COLS*ROWS-1. busy=1. Afterwards cursor=0,0, top_row=0, wrapped cleared, return to IDLE.
- Latency: a printable byte whose rx_ready is high in cycle N, with the FSM idle and the FIFO empty, gives vram_ce=1 in cycle N+2 with registered address and data.
- At most one VRAM write per cycle. vram_ce is never high for two cycles within a single printable/BS command.
- During any clear, incoming bytes continue to be buffered. Overflow is possible only if more than FIFO_DEPTH bytes arrive during a clear.
- busy is high in every cycle of CLEAR_ROW and CLEAR_SCREEN and low otherwise.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> 750 consecutive vram_ce pulses, data 0x20, addresses 0..749, busy high throughout. Then cursor=0,0 and busy=0.
- Send "AB" (0x41, 0x42) -> writes (0,0x41) and (1,0x42), each vram_ce 2 cycles after its rx_ready. cursor_col=2.
- Send 0x41, 0x08, 0x0D -> write 0x41 at 0, write 0x20 at 0. A further 0x08 at col 0 produces no write. cursor_col=0.
- Send 50 printable bytes -> last write at address 49. Then 50-cycle clear of addresses 50..99, cursor=row 1, col 0.
- Send 15 LFs from 0,0 -> row wraps to 0, wrapped set, top_row=1, row 0 cleared at addresses 0..49. The next LF gives top_row=2.
- During a 750-cycle FF clear, push 5 bytes with FIFO_DEPTH=4 -> fifth byte dropped, overflow=1. The first 4 execute after the clear. Assert reset mid-clear -> vram_ce=0 immediately and all outputs return to 0.
